// File: rtl/nonrestoring_div_seq.sv
// Sequential non-restoring unsigned divider: one quotient bit per clock,
// followed by a single remainder-correction cycle.
module nonrestoring_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Handshake: start is accepted only on an edge where busy=0; done is a
    // single-cycle pulse and the result registers hold until the next done.
    state_t state, state_nx;

    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic             sub;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   d_op;
    logic [WIDTH:0]   r_new;
    logic [WIDTH:0]   r_fix;

    // Controlled add/subtract row: sub inverts D and supplies the carry-in.
    always_comb begin
        sub   = ~r[WIDTH];
        r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
        d_op  = {1'b0, d} ^ {(WIDTH+1){sub}};
        r_new = r_sh + d_op + {{WIDTH{1'b0}}, sub};
        r_fix = r[WIDTH] ? (r + {1'b0, d}) : r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            d           <= divisor;
                            q           <= dividend;
                            r           <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r   <= r_new;
                    q   <= {q[WIDTH-2:0], ~r_new[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    r         <= r_fix;
                    quotient  <= q;
                    remainder <= r_fix[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
